// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode encoding, legality check
// and default datapath/register-address widths.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010
    } alu_op_e;

    function automatic logic is_legal_op(alu_op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL,
            OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA: is_legal_op = 1'b1;
            default:                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_hazard_unit.sv
// RAW hazard detection and bypass selection for the ALU issue stage.
// Build option: ALU_ISSUE_BYPASS_EN enables the W-stage result bypass.
module alu_hazard_unit #(
    parameter int RA_W = 5
) (
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_use_imm,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic            x_vld,
    input  logic [RA_W-1:0] x_rd,
    input  logic            w_vld,
    input  logic [RA_W-1:0] w_rd,
    output logic            hazard,
    output logic            in_ready,
    output logic            byp1,
    output logic            byp2
);

    logic x_hit;

`ifdef ALU_ISSUE_BYPASS_EN
    always_comb begin
        x_hit = x_vld && (x_rd != '0)
             && ((rs1 == x_rd) || (!in_use_imm && (rs2 == x_rd)));
        hazard = in_valid && x_hit;
        byp1 = w_vld && (rs1 != '0) && (rs1 == w_rd);
        byp2 = w_vld && (rs2 != '0) && (rs2 == w_rd);
        in_ready = !rst && !hazard;
    end
`else
    logic w_hit;

    // Without a bypass the consumer waits until W has written the file.
    always_comb begin
        x_hit = x_vld && (x_rd != '0)
             && ((rs1 == x_rd) || (!in_use_imm && (rs2 == x_rd)));
        w_hit = w_vld && (w_rd != '0)
             && ((rs1 == w_rd) || (!in_use_imm && (rs2 == w_rd)));
        hazard = in_valid && (x_hit || w_hit);
        byp1 = 1'b0;
        byp2 = 1'b0;
        in_ready = !rst && !hazard;
    end
`endif

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage feeding a one-cycle ALU, with writeback to the RF.
// Build option: ALU_ISSUE_BYPASS_EN (bypass from alu_result; else stall).
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opcode,
    input  logic [RA_W-1:0] in_rd,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,
    output logic [RA_W-1:0] rf_raddr1,
    output logic [RA_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [3:0]      alu_opcode,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_en,
    output logic [RA_W-1:0] wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_op,
    output logic [31:0]     stall_cnt
);

    logic            hazard;
    logic            byp1;
    logic            byp2;
    logic            accept;
    logic            legal;
    logic            x_vld;
    logic            w_vld;
    logic [RA_W-1:0] x_rd;
    logic [RA_W-1:0] w_rd;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    alu_hazard_unit #(
        .RA_W(RA_W)
    ) u_hazard (
        .rst       (rst),
        .in_valid  (in_valid),
        .in_use_imm(in_use_imm),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .x_vld     (x_vld),
        .x_rd      (x_rd),
        .w_vld     (w_vld),
        .w_rd      (w_rd),
        .hazard    (hazard),
        .in_ready  (in_ready),
        .byp1      (byp1),
        .byp2      (byp2)
    );

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal_op(alu_op_e'(in_opcode));

    always_comb begin
        opa = '0;
        if (in_rs1 != '0) begin
            opa = byp1 ? alu_result : rf_rdata1;
        end
        opb = in_imm;
        if (!in_use_imm) begin
            opb = '0;
            if (in_rs2 != '0) begin
                opb = byp2 ? alu_result : rf_rdata2;
            end
        end
    end

    // Illegal ops never reach X, so the ALU inputs keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_vld      <= 1'b0;
            w_vld      <= 1'b0;
            x_rd       <= '0;
            w_rd       <= '0;
            illegal_op <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            stall_cnt  <= '0;
        end else begin
            x_vld      <= accept && legal;
            illegal_op <= accept && !legal;
            if (accept && legal) begin
                alu_opcode <= in_opcode;
                alu_a      <= opa;
                alu_b      <= opb;
                x_rd       <= in_rd;
            end
            w_vld <= x_vld;
            w_rd  <= x_rd;
            if (hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign wb_en   = w_vld && (w_rd != '0) && !rst;
    assign wb_addr = w_rd;
    assign wb_data = alu_result;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, a mid-flight reset sequence
// and a random stream checked against an in-order architectural model.
module tb_alu_issue;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_imm = '0;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic [31:0] stall_cnt;

    alu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_use_imm(in_use_imm),
        .in_imm    (in_imm),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .illegal_op(illegal_op),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            1:       return 32'h8000_0000;
            2:       return 32'd5;
            4:       return 32'h0000_00F0;
            5:       return 32'h0000_000F;
            10:      return 32'h0001_0000;
            default: return 32'(i) * 32'h0101_0101;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a * b;
            4'h4:    return a & b;
            4'h6:    return a | b;
            4'h7:    return a ^ b;
            4'h8:    return a << b[4:0];
            4'h9:    return a >> b[4:0];
            4'hA:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic legal_ref(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    endfunction

    // External register file and registered ALU around the DUT
    logic [31:0] rf [32];
    logic        preload = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        alu_result <= alu_ref(alu_opcode, alu_a, alu_b);
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t wb_obs[$];
    wb_t wb_exp[$];
    int  obs_ptr = 0;

    always @(negedge clk) begin
        if (wb_en) wb_obs.push_back(wb_t'{wb_addr, wb_data});
    end

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ui;
        logic [31:0] imm;
        int          stall;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        wb;
        logic [31:0] res;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] arch [32];
    int          rdy [32];
    int          checks = 0;
    int          errors = 0;

    logic [3:0] legal_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [3:0] bad_ops [7] = '{4'h3, 4'h5, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic ui, input logic [31:0] imm,
                         output int stalls, output int acc);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = ui;
        in_imm     = imm;
        stalls     = 0;
        acc        = -1;
        for (int k = 0; k < 8 && acc < 0; k++) begin
            @(negedge clk);
            if (in_ready) acc = cyc;
            else stalls++;
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", stalls);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag);
        int n;
        n = wb_obs.size() - obs_ptr;
        chk({tag, "_wb_count"}, 32'(n), 32'(wb_exp.size()));
        for (int i = 0; i < wb_exp.size() && i < n; i++) begin
            chk($sformatf("%s_wb%0d_addr", tag, i), 32'(wb_obs[obs_ptr + i].addr),
                32'(wb_exp[i].addr));
            chk($sformatf("%s_wb%0d_data", tag, i), wb_obs[obs_ptr + i].data,
                wb_exp[i].data);
        end
        obs_ptr = wb_obs.size();
        wb_exp.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          ac;
        int          c;
        int          need;
        int          exp_st;
        int          stall_total;
        logic [3:0]  last_op;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ui;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;

        vt[0] = '{4'hA, 5'd8, 5'd1, 5'd0, 1'b1, 32'd4, 0, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000};
        vt[1] = '{4'h2, 5'd9, 5'd10, 5'd0, 1'b1, 32'h0001_0000, 0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0};
        vt[2] = '{4'h0, 5'd1, 5'd2, 5'd0, 1'b1, 32'd7, 0, 32'd5, 32'd7, 1'b1, 32'd12};
        vt[3] = '{4'h7, 5'd3, 5'd4, 5'd5, 1'b0, 32'd0, 0, 32'hF0, 32'h0F, 1'b1, 32'hFF};
        vt[4] = '{4'h0, 5'd1, 5'd0, 5'd0, 1'b1, 32'd3, 0, 32'd0, 32'd3, 1'b1, 32'd3};
        vt[5] = '{4'h1, 5'd2, 5'd1, 5'd0, 1'b1, 32'd1, LAT - 1, 32'd3, 32'd1, 1'b1, 32'd2};
        vt[6] = '{4'h3, 5'd6, 5'd1, 5'd0, 1'b1, 32'd0, 0, 32'd0, 32'd0, 1'b0, 32'd0};
        vt[7] = '{4'h0, 5'd7, 5'd1, 5'd0, 1'b1, 32'd10, 0, 32'd3, 32'd10, 1'b1, 32'd13};
        vt[8] = '{4'h0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd9, 0, 32'd0, 32'd9, 1'b0, 32'd0};
        vt[9] = '{4'h6, 5'd1, 5'd0, 5'd0, 1'b1, 32'd0, 0, 32'd0, 32'd0, 1'b1, 32'd0};

        rst     = 1'b1;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_wb_en", 32'(wb_en), 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_illegal_op", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) arch[i] = init_val(i);

        last_op = 4'h0;
        for (int i = 0; i < 10; i++) begin
            issue(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].ui, vt[i].imm, st, ac);
            chk($sformatf("v%0d_stall", i), 32'(st), 32'(vt[i].stall));
            if (legal_ref(vt[i].op)) begin
                chk($sformatf("v%0d_alu_opcode", i), 32'(alu_opcode), 32'(vt[i].op));
                chk($sformatf("v%0d_alu_a", i), alu_a, vt[i].exp_a);
                chk($sformatf("v%0d_alu_b", i), alu_b, vt[i].exp_b);
                chk($sformatf("v%0d_illegal_op", i), 32'(illegal_op), 32'd0);
                last_op = vt[i].op;
            end else begin
                chk($sformatf("v%0d_illegal_op", i), 32'(illegal_op), 32'd1);
                chk($sformatf("v%0d_alu_opcode_hold", i), 32'(alu_opcode), 32'(last_op));
            end
            if (vt[i].wb) begin
                wb_exp.push_back(wb_t'{vt[i].rd, vt[i].res});
                arch[vt[i].rd] = vt[i].res;
            end
        end
        drain(4);
        check_wb("table");
        chk("table_stall_cnt", stall_cnt, 32'(LAT - 1));

        // Reset while ADD r11 sits in W and SUB r12 sits in X
        issue(4'h0, 5'd11, 5'd2, 5'd0, 1'b1, 32'd1, st, ac);
        issue(4'h1, 5'd12, 5'd4, 5'd0, 1'b1, 32'd2, st, ac);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_opcode  = 4'h0;
        in_rd      = 5'd13;
        in_rs1     = 5'd12;
        in_use_imm = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_wb_en_during", 32'(wb_en), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_wb_en", 32'(wb_en), 32'd0);
        chk("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_illegal_op", 32'(illegal_op), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        drain(4);
        check_wb("midrst");

        // Random stream: in-order architectural model plus operand-ready times
        for (int i = 0; i < 32; i++) rdy[i] = 0;
        stall_total = 0;
        for (int n = 0; n < 300; n++) begin
            op = legal_ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 6)];
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            ui  = 1'($urandom_range(0, 1));
            imm = $urandom();
            a = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
            b = ui ? imm : ((rs2 == 5'd0) ? 32'd0 : arch[rs2]);
            need = rdy[rs1];
            if (!ui && rdy[rs2] > need) need = rdy[rs2];
            issue(op, rd, rs1, rs2, ui, imm, st, ac);
            c = ac - st;
            exp_st = (need > c) ? need - c : 0;
            stall_total += exp_st;
            chk($sformatf("r%0d_stall", n), 32'(st), 32'(exp_st));
            if (legal_ref(op)) begin
                chk($sformatf("r%0d_alu_opcode", n), 32'(alu_opcode), 32'(op));
                chk($sformatf("r%0d_alu_a", n), alu_a, a);
                chk($sformatf("r%0d_alu_b", n), alu_b, b);
                chk($sformatf("r%0d_illegal_op", n), 32'(illegal_op), 32'd0);
                if (rd != 5'd0) begin
                    res = alu_ref(op, a, b);
                    arch[rd] = res;
                    wb_exp.push_back(wb_t'{rd, res});
                    rdy[rd] = c + exp_st + LAT;
                end
            end else begin
                chk($sformatf("r%0d_illegal_op", n), 32'(illegal_op), 32'd1);
            end
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain(4);
        check_wb("rand");
        chk("rand_stall_cnt", stall_cnt, 32'(stall_total));
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("final_r%0d", i), rf[i], arch[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
